// File: rtl/sn_pkg.sv
// ---------------------------------------------------------------------------
// sn_pkg
// Shared constants, state encoding and LFSR helper functions for the
// stochastic-number pair source.
//   LFSR_W / TAP_HI / TAP_LO : 31-bit maximal-length LFSR, x^31 + x^28 + 1
//   PROB_W                   : probability width; compared against lfsr[PROB_W-1:0]
//   WINDOW                   : samples per frame (downstream averaging period)
//   SEED_A / SEED_B          : reset and default seeds of the two LFSRs
// ---------------------------------------------------------------------------
package sn_pkg;

    localparam int LFSR_W  = 31;
    localparam int TAP_HI  = 30;
    localparam int TAP_LO  = 27;
    localparam int PROB_W  = 4;
    localparam int WINDOW  = 129;
    localparam int PHASE_W = 8;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(WINDOW - 1);

    localparam logic [LFSR_W-1:0] SEED_A = 31'd1;
    localparam logic [LFSR_W-1:0] SEED_B = 31'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } sn_state_e;

    // One LFSR step: shift toward the MSB, feedback enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[TAP_HI] ^ v[TAP_LO]};
    endfunction

    // The all-zero state is a fixed point of the LFSR; map it to 1.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] v);
        logic [LFSR_W-1:0] r;
        if (v == {LFSR_W{1'b0}}) begin
            r = {{(LFSR_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/sn_lfsr_cmp.sv
// ---------------------------------------------------------------------------
// sn_lfsr_cmp
// One stochastic-bit generator: a 31-bit LFSR followed by a registered
// magnitude comparator against the active probability.
// Ports:
//   clk, rst_n   : clock, asynchronous active-high reset
//   step_i       : advance the LFSR and produce a sample this cycle
//   load_i       : load load_val_i into the LFSR (zero is replaced by 1)
//   load_val_i   : seed value
//   prob_i       : probability used for the comparison
//   sn_o         : registered stochastic bit (0 when not stepping)
// ---------------------------------------------------------------------------
module sn_lfsr_cmp
    import sn_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = SEED_A
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_val_i,
    input  logic [PROB_W-1:0] prob_i,
    output logic              sn_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic              sn_q;
    logic              sn_d;

    // Next LFSR state and comparator result; the sample uses the pre-step state.
    always_comb begin
        lfsr_d = lfsr_q;
        sn_d   = 1'b0;
        if (load_i) begin
            lfsr_d = seed_fix(load_val_i);
        end else if (step_i) begin
            lfsr_d = lfsr_step(lfsr_q);
            sn_d   = (lfsr_q[PROB_W-1:0] < prob_i);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR and output sample registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lfsr_q <= SEED;
            sn_q   <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            sn_q   <= sn_d;
        end
    end

    assign sn_o = sn_q;

endmodule

// File: rtl/sn_pair_source.sv
// ---------------------------------------------------------------------------
// sn_pair_source
// Produces two decorrelated stochastic bitstreams (sn_a, sn_b) framed in
// WINDOW-sample frames. Probability pairs arrive over a valid/ready
// handshake and only take effect at frame boundaries while streaming.
// Ports:
//   clk, rst_n               : clock, asynchronous active-high reset
//   run_en                   : level request to stream
//   cfg_valid / cfg_ready    : probability-pair handshake (ready = shadow empty)
//   cfg_prob_a / cfg_prob_b  : offered probabilities
//   seed_valid/sel/data      : LFSR seed write (IDLE only)
//   seed_err                 : one-cycle pulse when a seed write is rejected
//   sn_a, sn_b, sn_valid     : registered sample outputs
//   frame_start              : marks the first sample of each frame
//   prob_a_act / prob_b_act  : probabilities currently in use
// ---------------------------------------------------------------------------
module sn_pair_source
    import sn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [PROB_W-1:0] cfg_prob_a,
    input  logic [PROB_W-1:0] cfg_prob_b,
    input  logic              seed_valid,
    input  logic              seed_sel,
    input  logic [LFSR_W-1:0] seed_data,
    output logic              seed_err,
    output logic              sn_a,
    output logic              sn_b,
    output logic              sn_valid,
    output logic              frame_start,
    output logic [PROB_W-1:0] prob_a_act,
    output logic [PROB_W-1:0] prob_b_act
);

    sn_state_e          state_q;
    sn_state_e          state_d;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    logic               shadow_full_q;
    logic               shadow_full_d;
    logic [PROB_W-1:0]  shadow_a_q;
    logic [PROB_W-1:0]  shadow_a_d;
    logic [PROB_W-1:0]  shadow_b_q;
    logic [PROB_W-1:0]  shadow_b_d;
    logic [PROB_W-1:0]  act_a_q;
    logic [PROB_W-1:0]  act_a_d;
    logic [PROB_W-1:0]  act_b_q;
    logic [PROB_W-1:0]  act_b_d;

    logic               seed_err_q;
    logic               sn_valid_q;
    logic               frame_start_q;

    logic               active_s;
    logic               boundary_s;
    logic               cfg_accept_s;
    logic               load_a_s;
    logic               load_b_s;

    assign active_s     = (state_q != IDLE);
    assign boundary_s   = active_s && (phase_q == PHASE_LAST);
    assign cfg_accept_s = cfg_valid && !shadow_full_q;
    assign load_a_s     = seed_valid && !active_s && !seed_sel;
    assign load_b_s     = seed_valid && !active_s &&  seed_sel;

    // FSM next state and phase counter; a stop only lands on a frame boundary.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (run_en) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!run_en) begin
                    state_d = STOP_PEND;
                end else begin
                    state_d = RUN;
                end
            end
            STOP_PEND: begin
                if (run_en) begin
                    state_d = RUN;
                end else if (boundary_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP_PEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!active_s) begin
            phase_d = {PHASE_W{1'b0}};
        end else if (boundary_s) begin
            phase_d = {PHASE_W{1'b0}};
        end else begin
            phase_d = phase_q + 8'd1;
        end
    end

    // Shadow/active probability registers and the config handshake.
    always_comb begin
        shadow_full_d = shadow_full_q;
        shadow_a_d    = shadow_a_q;
        shadow_b_d    = shadow_b_q;
        act_a_d       = act_a_q;
        act_b_d       = act_b_q;
        if (active_s) begin
            // A pair accepted on the boundary cycle itself found the shadow
            // empty, so it is not promoted until the next boundary.
            if (boundary_s && shadow_full_q) begin
                act_a_d       = shadow_a_q;
                act_b_d       = shadow_b_q;
                shadow_full_d = 1'b0;
            end else begin
                shadow_full_d = shadow_full_q;
            end
            if (cfg_accept_s) begin
                shadow_a_d    = cfg_prob_a;
                shadow_b_d    = cfg_prob_b;
                shadow_full_d = 1'b1;
            end else begin
                shadow_a_d    = shadow_a_q;
            end
        end else begin
            // A pair captured on the very last streamed cycle is still parked
            // in the shadow once IDLE is reached; promote it here.
            if (shadow_full_q) begin
                act_a_d       = shadow_a_q;
                act_b_d       = shadow_b_q;
                shadow_full_d = 1'b0;
            end else if (cfg_accept_s) begin
                act_a_d       = cfg_prob_a;
                act_b_d       = cfg_prob_b;
            end else begin
                act_a_d       = act_a_q;
            end
        end
    end

    // State, phase, probability and output-flag registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q       <= IDLE;
            phase_q       <= {PHASE_W{1'b0}};
            shadow_full_q <= 1'b0;
            shadow_a_q    <= {PROB_W{1'b0}};
            shadow_b_q    <= {PROB_W{1'b0}};
            act_a_q       <= {PROB_W{1'b0}};
            act_b_q       <= {PROB_W{1'b0}};
            seed_err_q    <= 1'b0;
            sn_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            shadow_full_q <= shadow_full_d;
            shadow_a_q    <= shadow_a_d;
            shadow_b_q    <= shadow_b_d;
            act_a_q       <= act_a_d;
            act_b_q       <= act_b_d;
            seed_err_q    <= seed_valid && active_s;
            sn_valid_q    <= active_s;
            frame_start_q <= active_s && (phase_q == {PHASE_W{1'b0}});
        end
    end

    sn_lfsr_cmp #(
        .SEED       (SEED_A)
    ) u_gen_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_i     (active_s),
        .load_i     (load_a_s),
        .load_val_i (seed_data),
        .prob_i     (act_a_q),
        .sn_o       (sn_a)
    );

    sn_lfsr_cmp #(
        .SEED       (SEED_B)
    ) u_gen_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_i     (active_s),
        .load_i     (load_b_s),
        .load_val_i (seed_data),
        .prob_i     (act_b_q),
        .sn_o       (sn_b)
    );

    assign cfg_ready   = !shadow_full_q;
    assign seed_err    = seed_err_q;
    assign sn_valid    = sn_valid_q;
    assign frame_start = frame_start_q;
    assign prob_a_act  = act_a_q;
    assign prob_b_act  = act_b_q;

endmodule

// File: tb/tb_sn_pair_source.sv
// ---------------------------------------------------------------------------
// tb_sn_pair_source
// Reference model predicts each sample from the behavioural rules; a monitor
// pops predictions whenever sn_valid is seen and compares.
// ---------------------------------------------------------------------------
module tb_sn_pair_source;

    logic        clk;
    logic        rst_n;
    logic        run_en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_prob_a;
    logic [3:0]  cfg_prob_b;
    logic        seed_valid;
    logic        seed_sel;
    logic [30:0] seed_data;
    logic        seed_err;
    logic        sn_a;
    logic        sn_b;
    logic        sn_valid;
    logic        frame_start;
    logic [3:0]  prob_a_act;
    logic [3:0]  prob_b_act;

    sn_pair_source dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_en      (run_en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_prob_a  (cfg_prob_a),
        .cfg_prob_b  (cfg_prob_b),
        .seed_valid  (seed_valid),
        .seed_sel    (seed_sel),
        .seed_data   (seed_data),
        .seed_err    (seed_err),
        .sn_a        (sn_a),
        .sn_b        (sn_b),
        .sn_valid    (sn_valid),
        .frame_start (frame_start),
        .prob_a_act  (prob_a_act),
        .prob_b_act  (prob_b_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic a;
        logic b;
        logic fs;
    } samp_t;

    samp_t sq[$];
    logic  sa_log[$];
    logic  sb_log[$];
    logic  fs_log[$];

    // Reference model state: mode 0 = idle, 1 = running, 2 = stopping
    int          m_mode;
    int          m_phase;
    logic [30:0] m_la;
    logic [30:0] m_lb;
    int          m_act_a;
    int          m_act_b;
    int          m_shadow[$];
    logic        m_exp_valid;
    logic        m_exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [30:0] poly_next(input logic [30:0] x);
        return {x[29:0], x[30] ^ x[27]};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_phase = 0;
        m_la = 31'd1;
        m_lb = 31'd2;
        m_act_a = 0;
        m_act_b = 0;
        m_shadow.delete();
        sq.delete();
        m_exp_valid = 1'b0;
        m_exp_err = 1'b0;
    endtask

    task automatic model_step();
        bit active;
        bit accept;
        bit last;
        int p;
        active = (m_mode != 0);
        last   = (m_phase == 128);
        accept = cfg_valid && (m_shadow.size() == 0);
        m_exp_err = seed_valid && active;
        if (active) begin
            samp_t s;
            s.a  = ((int'(m_la) % 16) < m_act_a);
            s.b  = ((int'(m_lb) % 16) < m_act_b);
            s.fs = (m_phase == 0);
            sq.push_back(s);
            m_exp_valid = 1'b1;
            if (last && m_shadow.size() > 0) begin
                p = m_shadow.pop_front();
                m_act_a = p / 16;
                m_act_b = p % 16;
            end
            if (accept) m_shadow.push_back(int'(cfg_prob_a) * 16 + int'(cfg_prob_b));
            m_la = poly_next(m_la);
            m_lb = poly_next(m_lb);
        end else begin
            m_exp_valid = 1'b0;
            if (m_shadow.size() > 0) begin
                p = m_shadow.pop_front();
                m_act_a = p / 16;
                m_act_b = p % 16;
            end else if (accept) begin
                m_act_a = int'(cfg_prob_a);
                m_act_b = int'(cfg_prob_b);
            end
            if (seed_valid) begin
                if (seed_sel) m_lb = (seed_data == 31'd0) ? 31'd1 : seed_data;
                else          m_la = (seed_data == 31'd0) ? 31'd1 : seed_data;
            end
        end
        case (m_mode)
            0: if (run_en) m_mode = 1;
            1: if (!run_en) m_mode = 2;
            default: begin
                if (run_en) m_mode = 1;
                else if (last) m_mode = 0;
            end
        endcase
        m_phase = active ? (last ? 0 : m_phase + 1) : 0;
    endtask

    // Reference model, advanced on every clock edge; reset is asynchronous.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst_n);
            if (rst_n) model_reset();
            else model_step();
        end
    end

    // Monitor: compares DUT outputs against predictions on the falling edge.
    initial begin
        samp_t s;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("sn_valid", sn_valid, m_exp_valid);
                if (sn_valid) begin
                    if (sq.size() == 0) begin
                        check("unexpected_sample", 32'd1, 32'd0);
                    end else begin
                        s = sq.pop_front();
                        check("sn_a", sn_a, s.a);
                        check("sn_b", sn_b, s.b);
                        check("frame_start", frame_start, s.fs);
                        sa_log.push_back(sn_a);
                        sb_log.push_back(sn_b);
                        fs_log.push_back(frame_start);
                    end
                end else begin
                    check("idle_sn_a", sn_a, 32'd0);
                    check("idle_sn_b", sn_b, 32'd0);
                    check("idle_frame_start", frame_start, 32'd0);
                    while (sq.size() > 0) void'(sq.pop_front());
                end
                check("seed_err", seed_err, m_exp_err);
                check("cfg_ready", cfg_ready, (m_shadow.size() == 0));
                check("prob_a_act", prob_a_act, m_act_a);
                check("prob_b_act", prob_b_act, m_act_b);
            end
        end
    end

    task automatic clear_logs();
        sa_log.delete();
        sb_log.delete();
        fs_log.delete();
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while (!(m_mode != 0 && m_phase == p) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("wait_phase_timeout", (n >= 400), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_mode != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", (n >= 400), 32'd0);
    endtask

    // exp bit 4 is the first sample
    task automatic check_first5(input string name, input logic [4:0] ea,
                                input logic [4:0] eb, input logic [4:0] ef, input bit chk_b);
        int n = 0;
        while (sa_log.size() < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, (sa_log.size() < 5), 32'd0);
        if (sa_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("%s_a%0d", name, i), sa_log[i], ea[4-i]);
                if (chk_b) check($sformatf("%s_b%0d", name, i), sb_log[i], eb[4-i]);
                check($sformatf("%s_fs%0d", name, i), fs_log[i], ef[4-i]);
            end
        end
    endtask

    task automatic load_cfg(input logic [3:0] a, input logic [3:0] b);
        cfg_valid = 1'b1; cfg_prob_a = a; cfg_prob_b = b;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cfg_ready"}, cfg_ready, 32'd1);
        check({name, "_seed_err"}, seed_err, 32'd0);
        check({name, "_sn_a"}, sn_a, 32'd0);
        check({name, "_sn_b"}, sn_b, 32'd0);
        check({name, "_sn_valid"}, sn_valid, 32'd0);
        check({name, "_frame_start"}, frame_start, 32'd0);
        check({name, "_prob_a_act"}, prob_a_act, 32'd0);
        check({name, "_prob_b_act"}, prob_b_act, 32'd0);
    endtask

    // Stimulus
    initial begin
        rst_n = 1'b1; run_en = 1'b0; cfg_valid = 1'b0; cfg_prob_a = 4'd0; cfg_prob_b = 4'd0;
        seed_valid = 1'b0; seed_sel = 1'b0; seed_data = 31'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b0;
        @(negedge clk);

        // Basic run: known first samples from default seeds
        load_cfg(4'd2, 4'd5);
        clear_logs();
        run_en = 1'b1;
        check_first5("first", 5'b10001, 5'b11011, 5'b10000, 1'b1);
        repeat (300) @(negedge clk);

        // Mid-frame reconfiguration
        wait_phase(40);
        load_cfg(4'd15, 4'd0);
        check("cfg_ready_drop", cfg_ready, 32'd0);
        repeat (200) @(negedge clk);

        // Stop request, with a re-request while stopping
        wait_phase(10);
        run_en = 1'b0;
        wait_phase(60);
        run_en = 1'b1;
        @(negedge clk);
        run_en = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        // Seed write while running is rejected
        run_en = 1'b1;
        repeat (20) @(negedge clk);
        seed_valid = 1'b1; seed_sel = 1'b0; seed_data = 31'd123;
        @(negedge clk);
        seed_valid = 1'b0;
        repeat (50) @(negedge clk);
        run_en = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        // Zero seed is forced to 1
        seed_valid = 1'b1; seed_sel = 1'b0; seed_data = 31'd0;
        @(negedge clk);
        seed_valid = 1'b0;
        load_cfg(4'd2, 4'd5);
        clear_logs();
        run_en = 1'b1;
        check_first5("seed0", 5'b10001, 5'b00000, 5'b10000, 1'b0);

        // Asynchronous reset mid-frame
        wait_phase(60);
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_en = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        load_cfg(4'd2, 4'd5);
        clear_logs();
        run_en = 1'b1;
        check_first5("after_reset", 5'b10001, 5'b11011, 5'b10000, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) run_en = ~run_en;
            cfg_valid  = ($urandom_range(0, 9) == 0);
            cfg_prob_a = 4'($urandom_range(0, 15));
            cfg_prob_b = 4'($urandom_range(0, 15));
            seed_valid = ($urandom_range(0, 29) == 0);
            seed_sel   = 1'($urandom_range(0, 1));
            seed_data  = ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom);
        end
        @(negedge clk);
        cfg_valid = 1'b0; seed_valid = 1'b0; run_en = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("pending_samples", sq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
